// File: rtl/seq_detector_param.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : seq_detector_param                                         |
// | Description : Serial pattern detector with a runtime-loadable pattern,   |
// |               overlapping/non-overlapping detection and a registered     |
// |               match pulse. Define SEQ_DETECTOR_CNT_EN to build the       |
// |               saturating match counter; otherwise match_cnt is tied to 0.|
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module seq_detector_param #(
  parameter int              PAT_W     = 3,
  parameter logic [PAT_W-1:0] PAT_RESET = PAT_W'(3'b010),
  parameter int              CNT_W     = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             in,
  input  logic             load,
  input  logic [PAT_W-1:0] pattern,
  input  logic             overlap,
  output logic             out,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int               FILL_W     = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] c_FILL_MAX = FILL_W'(PAT_W);
  localparam logic [FILL_W-1:0] c_FILL_ARM = FILL_W'(PAT_W - 1);

  logic [PAT_W-1:0]  r_pat;
  logic [PAT_W-1:0]  r_shreg;
  logic [FILL_W-1:0] r_fill;
  logic              r_out;

  logic [PAT_W-1:0]  w_shreg_next;
  logic [FILL_W-1:0] w_fill_inc;
  logic              w_match;

  assign w_shreg_next = {r_shreg[PAT_W-2:0], in};
  assign w_fill_inc   = (r_fill == c_FILL_MAX) ? r_fill : r_fill + FILL_W'(1);
  // Current bit completes a match only once PAT_W-1 valid bits precede it.
  assign w_match      = (w_shreg_next == r_pat) && (r_fill >= c_FILL_ARM);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pat   <= PAT_RESET;
      r_shreg <= '0;
      r_fill  <= '0;
      r_out   <= 1'b0;
    end else if (load) begin
      r_pat   <= pattern;
      r_shreg <= '0;
      r_fill  <= '0;
      r_out   <= 1'b0;
    end else if (en) begin
      r_shreg <= w_shreg_next;
      r_out   <= w_match;
      if (w_match && !overlap) begin
        r_fill <= '0;
      end else begin
        r_fill <= w_fill_inc;
      end
    end else begin
      r_out <= 1'b0;
    end
  end

  assign out = r_out;

`ifdef SEQ_DETECTOR_CNT_EN
  localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

  logic [CNT_W-1:0] r_match_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_match_cnt <= '0;
    end else if (load) begin
      r_match_cnt <= '0;
    end else if (en && w_match && (r_match_cnt != c_CNT_MAX)) begin
      r_match_cnt <= r_match_cnt + CNT_W'(1);
    end
  end

  assign match_cnt = r_match_cnt;
`else
  assign match_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: doc/seq_detector_param.md
# seq_detector_param

Parametrised serial pattern detector: the successor to the fixed three-bit "010" Moore detector. Samples one serial bit per enabled clock and compares the last PAT_W bits against a runtime-loadable pattern. Pulses a registered match flag, with selectable overlapping or non-overlapping detection. Sits on the serial input path ahead of the framing/control logic and optionally keeps a saturating match count.

## Interface
Parameters:
- PAT_W, 3: pattern length in bits; legal range 2..32.
- PAT_RESET, 3'b010 (zero-extended to PAT_W): pattern in force after reset.
- CNT_W, 8: match counter width; legal range 1..16.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset), released synchronously to clk by the system.
- en  input  1  sample enable; in is consumed only when en=1.
- in  input  1  serial data bit.
- load  input  1  pattern load strobe.
- pattern  input  PAT_W  new pattern; sampled when load=1; bit PAT_W-1 is the first bit received.
- overlap  input  1  1 = overlapping detection, 0 = non-overlapping; level-sampled every cycle.
- out  output  1  registered match pulse.
- match_cnt  output  CNT_W  saturating match count (see Configuration).

## Operation
- State: pat_q[PAT_W-1:0], shreg[PAT_W-1:0] (newest bit in LSB), fill counter 0..PAT_W (saturating, width $clog2(PAT_W+1)), out, match_cnt.
- Reset (reset=0, asynchronous): pat_q=PAT_RESET, shreg=0, fill=0, out=0, match_cnt=0.
- Priority per edge: load > en > hold.
- load=1: pat_q<=pattern, shreg<=0, fill<=0, out<=0, match_cnt<=0; in and en ignored that cycle.
- en=1, load=0:
  - shreg<={shreg[PAT_W-2:0],in}; fill<=min(fill+1,PAT_W).
  - Match condition: {shreg[PAT_W-2:0],in}==pat_q AND fill>=PAT_W-1.
  - On match: out<=1; if overlap=0, fill<=0 so a new match needs PAT_W fresh bits.
  - No match: out<=0.
- en=0, load=0: shreg, fill and pat_q hold; out<=0. Bits straddling an en=0 gap still form one contiguous sequence.
- fill gating ensures no match is reported before PAT_W valid bits have arrived after reset or load.

## Timing
- Latency: out is high in the cycle immediately following the rising edge that samples the final pattern bit. This is Moore-style behaviour, as in the fixed detector.
- out is high for exactly one cycle per match. With overlap=1, back-to-back matches (for example pattern 111 on a stream of 1s) give out high on consecutive cycles.
- match_cnt updates on the same edge that sets out.
- Reset asserted mid-sequence clears all state immediately. Partial sequences are discarded, and out falls without waiting for clk.
- load asserted in the same cycle that would complete a match: the match is suppressed and out=0 next cycle.

## Configuration
- Macro SEQ_DETECTOR_CNT_EN:
  - Defined: match_cnt increments by 1 on each match and saturates at 2^CNT_W-1 (no wrap). It is cleared by reset and by load.
  - Undefined: no counter register is built and match_cnt is tied to 0. out behaviour is identical in both builds.

## Test plan
- Default pattern 010, overlap=1, en=1, stream 0,1,0,1,0 -> out high the cycle after bit 3 and the cycle after bit 5; match_cnt=2.
- Same stream with overlap=0 -> out high only after bit 3; match_cnt=1.
- Stream 0,1, then reset low for 1 cycle, then 0 -> no out pulse. Then 1,0 -> out pulse after the final 0.
- load with pattern=110, then stream 1,1,0 -> out pulse after bit 3. Stream 0,1,0 after a fresh load -> no pulse.
- Stream 0, then en=0 for 2 cycles with in=1, then 1,0 with en=1 -> single out pulse after the last 0; out=0 during the en=0 cycles.
- CNT_W=2, SEQ_DETECTOR_CNT_EN defined, overlap=1, stream 0,1,0,1,0,1,0,1,0 (4 matches) -> match_cnt ends at 3 (saturated). With the macro undefined -> match_cnt stays 0 and the out pulses are unchanged.
